// File: rtl/bus_slave_port.sv
// Serial-bus slave port: receives a serial address (and write data) from the
// arbiter-selected master, stores words in an internal memory, and returns
// read data serially on rd_bus. Reads can raise split so the arbiter can hand
// the bus to another master while the read latency elapses.
//
// Ports:
//   clk, rstn     - clock, asynchronous active-low reset
//   mode          - 1 = write, 0 = read; taken with the first address bit
//   wr_bus        - master->slave serial bit, MSB first
//   master_valid  - wr_bus bit valid
//   master_ready  - master accepts the rd_bus bit
//   rd_bus        - slave->master serial bit, MSB first
//   slave_ready   - slave accepts the wr_bus bit
//   slave_valid   - rd_bus bit valid
//   split         - split request to the arbiter
module bus_slave_port #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned MEM_DEPTH    = 4096,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned SPLIT_EN     = 0
) (
  input  logic clk,
  input  logic rstn,
  input  logic mode,
  input  logic wr_bus,
  input  logic master_valid,
  input  logic master_ready,
  output logic rd_bus,
  output logic slave_ready,
  output logic slave_valid,
  output logic split
);

  localparam int unsigned MAX_W  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned CNT_W  = $clog2(MAX_W + 1);
  localparam int unsigned LAT_W  = $clog2(READ_LATENCY + 1);
  localparam int unsigned MIDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned AW1    = ADDR_WIDTH + 1;
  localparam logic [AW1-1:0] DEPTH_L = AW1'(MEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_WRITE = 3'd3,
    S_RWAIT = 3'd4,
    S_SPLIT = 3'd5,
    S_RDATA = 3'd6
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       bcnt_q, bcnt_d;
  logic [LAT_W-1:0]       lcnt_q, lcnt_d;
  logic                   mode_q, mode_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]  rsh_q, rsh_d;

  logic rd_bus_q, rd_bus_d;
  logic slave_ready_q, slave_ready_d;
  logic slave_valid_q, slave_valid_d;
  logic split_q, split_d;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic                  xfer_in;
  logic                  xfer_out;
  logic                  addr_in_range;
  logic [MIDX_W-1:0]     mem_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  assign xfer_in       = master_valid && slave_ready_q;
  assign xfer_out      = slave_valid_q && master_ready;
  assign addr_in_range = ({1'b0, addr_q} < DEPTH_L);
  assign mem_idx       = addr_q[MIDX_W-1:0];
  assign rd_word       = addr_in_range ? mem_q[mem_idx] : '0;

  assign rd_bus      = rd_bus_q;
  assign slave_ready = slave_ready_q;
  assign slave_valid = slave_valid_q;
  assign split       = split_q;

  // Phase that follows the last address bit.
  function automatic state_e after_addr(input logic m);
    if (m) begin
      return S_WDATA;
    end
    return (SPLIT_EN != 0) ? S_SPLIT : S_RWAIT;
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      bcnt_q        <= '0;
      lcnt_q        <= '0;
      mode_q        <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rsh_q         <= '0;
      rd_bus_q      <= 1'b0;
      slave_ready_q <= 1'b0;
      slave_valid_q <= 1'b0;
      split_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      bcnt_q        <= bcnt_d;
      lcnt_q        <= lcnt_d;
      mode_q        <= mode_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rsh_q         <= rsh_d;
      rd_bus_q      <= rd_bus_d;
      slave_ready_q <= slave_ready_d;
      slave_valid_q <= slave_valid_d;
      split_q       <= split_d;
    end
  end

  // Memory: not reset; an aborted transaction never reaches S_WRITE.
  always_ff @(posedge clk) begin
    if (state_q == S_WRITE && addr_in_range) begin
      mem_q[mem_idx] <= wdata_q;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    lcnt_d  = lcnt_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rsh_d   = rsh_q;

    case (state_q)
      S_IDLE: begin
        if (xfer_in) begin
          mode_d  = mode;
          addr_d  = ADDR_WIDTH'({addr_q, wr_bus});
          bcnt_d  = CNT_W'(1);
          state_d = S_ADDR;
          if (ADDR_WIDTH == 1) begin
            state_d = after_addr(mode);
            bcnt_d  = '0;
            lcnt_d  = LAT_W'(READ_LATENCY);
          end
        end
      end

      S_ADDR: begin
        if (xfer_in) begin
          addr_d = ADDR_WIDTH'({addr_q, wr_bus});
          bcnt_d = bcnt_q + CNT_W'(1);
          if (bcnt_q == CNT_W'(ADDR_WIDTH - 1)) begin
            state_d = after_addr(mode_q);
            bcnt_d  = '0;
            lcnt_d  = LAT_W'(READ_LATENCY);
          end
        end
      end

      S_WDATA: begin
        if (xfer_in) begin
          wdata_d = DATA_WIDTH'({wdata_q, wr_bus});
          bcnt_d  = bcnt_q + CNT_W'(1);
          if (bcnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            state_d = S_WRITE;
            bcnt_d  = '0;
          end
        end
      end

      S_WRITE: begin
        state_d = S_IDLE;
      end

      S_RWAIT, S_SPLIT: begin
        // Count down the latency; the zero cycle is the memory read cycle.
        if (lcnt_q == '0) begin
          rsh_d   = rd_word;
          state_d = S_RDATA;
          bcnt_d  = '0;
        end else begin
          lcnt_d = lcnt_q - LAT_W'(1);
        end
      end

      S_RDATA: begin
        if (xfer_out) begin
          rsh_d  = DATA_WIDTH'({rsh_q, 1'b0});
          bcnt_d = bcnt_q + CNT_W'(1);
          if (bcnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            state_d = S_IDLE;
            bcnt_d  = '0;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        bcnt_d  = '0;
      end
    endcase
  end

  // Registered outputs, decoded from the next state.
  always_comb begin
    rd_bus_d      = 1'b0;
    slave_ready_d = 1'b0;
    slave_valid_d = 1'b0;
    split_d       = 1'b0;

    case (state_d)
      S_IDLE, S_ADDR, S_WDATA: slave_ready_d = 1'b1;
      S_RDATA: begin
        slave_valid_d = 1'b1;
        rd_bus_d      = rsh_d[DATA_WIDTH-1];
      end
      // Split covers the READ_LATENCY countdown cycles, not the read cycle.
      S_SPLIT: split_d = (lcnt_d != '0);
      default: begin
        rd_bus_d      = 1'b0;
        slave_ready_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_slave_port.sv
// Directed bench for bus_slave_port: instance 0 uses MEM_DEPTH = 2048 with
// default latency and no split; instance 1 uses SPLIT_EN = 1, READ_LATENCY = 4.
module tb_bus_slave_port;

  logic clk;
  logic rstn;
  logic mode_i [2];
  logic wr_i   [2];
  logic mv_i   [2];
  logic mr_i   [2];
  logic rd_o   [2];
  logic sr_o   [2];
  logic sv_o   [2];
  logic sp_o   [2];

  int total = 0;
  int bad   = 0;

  bus_slave_port #(
    .ADDR_WIDTH(12), .DATA_WIDTH(8), .MEM_DEPTH(2048), .READ_LATENCY(2), .SPLIT_EN(0)
  ) dut0 (
    .clk(clk), .rstn(rstn), .mode(mode_i[0]), .wr_bus(wr_i[0]),
    .master_valid(mv_i[0]), .master_ready(mr_i[0]), .rd_bus(rd_o[0]),
    .slave_ready(sr_o[0]), .slave_valid(sv_o[0]), .split(sp_o[0])
  );

  bus_slave_port #(
    .ADDR_WIDTH(12), .DATA_WIDTH(8), .MEM_DEPTH(4096), .READ_LATENCY(4), .SPLIT_EN(1)
  ) dut1 (
    .clk(clk), .rstn(rstn), .mode(mode_i[1]), .wr_bus(wr_i[1]),
    .master_valid(mv_i[1]), .master_ready(mr_i[1]), .rd_bus(rd_o[1]),
    .slave_ready(sr_o[1]), .slave_valid(sv_o[1]), .split(sp_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Send n bits of v MSB-first; inputs change on negedge, transfer on posedge.
  task automatic send_bits(input int d, input logic [31:0] v, input int n, input bit gap,
                           input bit glitch, input logic m, output bit rdy_ok);
    rdy_ok = 1'b1;
    for (int i = n - 1; i >= 0; i--) begin
      mode_i[d] = (glitch && i != n - 1) ? ~m : m;
      wr_i[d]   = v[i];
      mv_i[d]   = 1'b1;
      if (sr_o[d] !== 1'b1) rdy_ok = 1'b0;
      @(negedge clk);
      if (gap && i > 0) begin
        mv_i[d] = 1'b0;
        wr_i[d] = ~v[i];
        @(negedge clk);
      end
    end
    mv_i[d] = 1'b0;
  endtask

  task automatic wr_txn(input int d, input logic [11:0] a, input logic [7:0] v,
                        input bit gap, input string tag);
    bit ok;
    send_bits(d, {12'd0, a, v}, 20, gap, 1'b0, 1'b1, ok);
    chk({tag, "_ready20"}, 32'(ok), 1);
    chk({tag, "_ready_in_write"}, 32'(sr_o[d]), 0);
    @(negedge clk);
    mode_i[d] = 1'b0;
    chk({tag, "_ready_idle"}, 32'(sr_o[d]), 1);
  endtask

  task automatic rd_txn(input int d, input logic [11:0] a, input logic [7:0] exp,
                        input bit toggle, input bit glitch, input string tag);
    bit rdy_ok, wait_ok, hold_ok, tmo;
    int lat, spl, svc;
    logic spl0, hb;
    logic [7:0] got;
    int exp_lat, exp_spl;
    exp_lat = (d == 1) ? 5 : 3;
    exp_spl = (d == 1) ? 4 : 0;
    send_bits(d, {20'd0, a}, 12, 1'b0, glitch, 1'b0, rdy_ok);
    mode_i[d] = 1'b0;
    lat = 0; spl = 0; spl0 = sp_o[d]; wait_ok = 1'b1; tmo = 1'b0;
    while (sv_o[d] !== 1'b1 && !tmo) begin
      if (sp_o[d] === 1'b1) spl++;
      if (sr_o[d] !== 1'b0) wait_ok = 1'b0;
      @(negedge clk);
      lat++;
      if (lat > 40) tmo = 1'b1;
    end
    got = '0; svc = 0; hold_ok = 1'b1;
    for (int b = 0; b < 8 && !tmo; b++) begin
      if (toggle) begin
        mr_i[d] = 1'b0;
        hb = rd_o[d];
        if (sv_o[d] === 1'b1) svc++;
        @(negedge clk);
        if (rd_o[d] !== hb) hold_ok = 1'b0;
      end
      mr_i[d] = 1'b1;
      got = {got[6:0], rd_o[d]};
      if (sv_o[d] === 1'b1) svc++;
      @(negedge clk);
    end
    mr_i[d] = 1'b0;
    chk({tag, "_timeout"}, 32'(tmo), 0);
    chk({tag, "_addr_ready"}, 32'(rdy_ok), 1);
    chk({tag, "_ready_low_wait"}, 32'(wait_ok), 1);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_split_cycles"}, 32'(spl), 32'(exp_spl));
    chk({tag, "_split_first"}, 32'(spl0), (exp_spl > 0) ? 1 : 0);
    chk({tag, "_data"}, 32'(got), 32'(exp));
    chk({tag, "_valid_cycles"}, 32'(svc), toggle ? 16 : 8);
    chk({tag, "_hold"}, 32'(hold_ok), 1);
    chk({tag, "_valid_drop"}, 32'(sv_o[d]), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    for (int d = 0; d < 2; d++) begin
      mode_i[d] = 1'b0; wr_i[d] = 1'b0; mv_i[d] = 1'b0; mr_i[d] = 1'b0;
    end
    rstn = 1'b0;
    #12;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst%0d_ready", d), 32'(sr_o[d]), 0);
      chk($sformatf("rst%0d_valid", d), 32'(sv_o[d]), 0);
      chk($sformatf("rst%0d_split", d), 32'(sp_o[d]), 0);
      chk($sformatf("rst%0d_rd", d), 32'(rd_o[d]), 0);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_ready0", 32'(sr_o[0]), 1);
    chk("post_rst_ready1", 32'(sr_o[1]), 1);

    // Write then read with continuous handshakes.
    wr_txn(0, 12'h123, 8'hA5, 1'b0, "wr123");
    chk("mem123_commit", 32'(dut0.mem_q[11'h123]), 32'hA5);
    rd_txn(0, 12'h123, 8'hA5, 1'b0, 1'b0, "rd123");

    // Backpressure on both directions.
    wr_txn(0, 12'h001, 8'h3C, 1'b1, "wr001_gap");
    rd_txn(0, 12'h001, 8'h3C, 1'b1, 1'b0, "rd001_toggle");

    // Split read on the split-enabled instance.
    wr_txn(1, 12'h0FF, 8'h81, 1'b0, "wr0ff_s");
    rd_txn(1, 12'h0FF, 8'h81, 1'b0, 1'b0, "rd0ff_split");

    // Out of range: 0x900 aliases 0x100 in the low index bits.
    wr_txn(0, 12'h100, 8'h4B, 1'b0, "wr100");
    wr_txn(0, 12'h900, 8'h77, 1'b0, "wr900_oor");
    chk("mem100_unchanged", 32'(dut0.mem_q[11'h100]), 32'h4B);
    rd_txn(0, 12'h900, 8'h00, 1'b0, 1'b0, "rd900_oor");
    rd_txn(0, 12'h100, 8'h4B, 1'b0, 1'b0, "rd100");

    // Reset in the middle of a write data phase.
    wr_txn(0, 12'h010, 8'h12, 1'b0, "wr010");
    send_bits(0, 32'({12'd0, 12'h010, 8'hFF} >> 5), 15, 1'b0, 1'b0, 1'b1, ok);
    chk("abort_addr_ready", 32'(ok), 1);
    rstn = 1'b0;
    #1;
    chk("abort_rst_ready", 32'(sr_o[0]), 0);
    chk("abort_rst_valid", 32'(sv_o[0]), 0);
    chk("abort_rst_split", 32'(sp_o[0]), 0);
    chk("abort_rst_rd", 32'(rd_o[0]), 0);
    mode_i[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("abort_ready_after", 32'(sr_o[0]), 1);
    rd_txn(0, 12'h010, 8'h12, 1'b0, 1'b0, "rd010_after_abort");
    rd_txn(1, 12'h0FF, 8'h81, 1'b0, 1'b0, "rd0ff_retained");

    // Mode changes during the address phase are ignored.
    wr_txn(0, 12'h005, 8'h5A, 1'b0, "wr005");
    rd_txn(0, 12'h005, 8'h5A, 1'b0, 1'b1, "rd005_glitch");
    rd_txn(0, 12'h005, 8'h5A, 1'b0, 1'b0, "rd005_again");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
